// File: rtl/pit_ctrl.sv
// pit_ctrl: sequencer for the PIT modulo counter.
// Drives the counter enable, the prescaled increment, the flag-clear pulse and the
// active modulus. The modulus is shadowed and only committed at ARM or right after a
// rollover, so register writes while the counter runs never corrupt a period.
// Periodic and one-shot operation. Owns the interrupt request level.
module pit_ctrl #(
    parameter int unsigned COUNT_SIZE = 16,
    parameter int unsigned PRE_BITS   = 15
) (
    input  logic                  bus_clk,
    input  logic                  async_rst_b,
    input  logic                  sync_reset,
    input  logic                  cfg_en,
    input  logic                  cfg_one_shot,
    input  logic                  cfg_irq_en,
    input  logic [3:0]            cfg_pre_sel,
    input  logic [COUNT_SIZE-1:0] cfg_mod,
    input  logic                  cfg_mod_wr,
    input  logic                  irq_clr,
    input  logic                  pit_i,
    output logic                  counter_sync,
    output logic                  prescale_out,
    output logic                  pit_flg_clr,
    output logic [COUNT_SIZE-1:0] mod_value,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  irq_o
);

    localparam int unsigned SEL_W = $clog2(PRE_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_STOP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [PRE_BITS-1:0]   pre_cnt_q;
    logic [PRE_BITS-1:0]   pre_cnt_d;
    logic [PRE_BITS-1:0]   pre_mask;
    logic [SEL_W-1:0]      pre_sel_q;
    logic [SEL_W-1:0]      pre_sel_d;
    int unsigned           sel_clamp;
    int unsigned           sel_eff;
    logic [COUNT_SIZE-1:0] shadow_q;
    logic [COUNT_SIZE-1:0] shadow_d;
    logic [COUNT_SIZE-1:0] mod_d;
    logic                  pending_q;
    logic                  pending_d;
    logic                  pit_run;
    logic                  counter_sync_d;
    logic                  prescale_d;
    logic                  flg_clr_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  irq_d;

    assign sel_clamp = (32'(cfg_pre_sel) > PRE_BITS) ? PRE_BITS : 32'(cfg_pre_sel);

    // State register: soft reset returns to IDLE ahead of any other input
    always_ff @(posedge bus_clk or negedge async_rst_b) begin
        if (!async_rst_b) begin
            state_q <= ST_IDLE;
        end else if (sync_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: run request, one-shot completion and abort
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cfg_en) state_d = ST_ARM;
            ST_ARM:  state_d = ST_RUN;
            ST_RUN: begin
                if (!cfg_en) begin
                    state_d = ST_IDLE;
                end else if (pit_i && cfg_one_shot) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: if (!cfg_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: outputs are registered from the next state, so they line up
    // with the state they describe rather than lagging it by a cycle
    always_comb begin
        pit_run   = (state_q == ST_RUN) && pit_i;
        pre_sel_d = (state_q == ST_ARM) ? SEL_W'(sel_clamp) : pre_sel_q;
        sel_eff   = (state_q == ST_ARM) ? sel_clamp : 32'(pre_sel_q);

        pre_mask = '0;
        for (int unsigned i = 0; i < PRE_BITS; i++) begin
            pre_mask[i] = (i < sel_eff);
        end

        // count holds the RUN-cycle index, so the 2^sel-th RUN cycle is the first pulse
        pre_cnt_d = ((state_q == ST_RUN) && (state_d == ST_RUN)) ?
                    pre_cnt_q + PRE_BITS'(1) : '0;

        counter_sync_d = (state_d == ST_RUN);
        prescale_d     = (state_d == ST_RUN) && ((pre_cnt_d & pre_mask) == pre_mask);
        busy_d         = (state_d == ST_ARM) || (state_d == ST_RUN);
        done_d         = (state_d == ST_STOP);

        // a write coinciding with rollover bypasses the shadow entirely
        shadow_d  = shadow_q;
        pending_d = pending_q;
        mod_d     = mod_value;
        if (cfg_mod_wr && pit_run) begin
            mod_d     = cfg_mod;
            shadow_d  = cfg_mod;
            pending_d = 1'b0;
        end else begin
            if (pending_q && ((state_q == ST_ARM) || pit_run)) begin
                mod_d     = shadow_q;
                pending_d = 1'b0;
            end
            if (cfg_mod_wr) begin
                shadow_d  = cfg_mod;
                pending_d = 1'b1;
            end
        end

        // a rollover set beats a simultaneous clear
        if (pit_run && cfg_irq_en) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_o;
        end
        flg_clr_d = irq_clr;
    end

    // Output and datapath registers: soft reset keeps the modulus path intact
    always_ff @(posedge bus_clk or negedge async_rst_b) begin
        if (!async_rst_b) begin
            pre_cnt_q    <= '0;
            pre_sel_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            mod_value    <= '0;
            counter_sync <= 1'b0;
            prescale_out <= 1'b0;
            pit_flg_clr  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            irq_o        <= 1'b0;
        end else if (sync_reset) begin
            pre_cnt_q    <= '0;
            pre_sel_q    <= '0;
            counter_sync <= 1'b0;
            prescale_out <= 1'b0;
            pit_flg_clr  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            irq_o        <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            pre_sel_q    <= pre_sel_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            mod_value    <= mod_d;
            counter_sync <= counter_sync_d;
            prescale_out <= prescale_d;
            pit_flg_clr  <= flg_clr_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
            irq_o        <= irq_d;
        end
    end

endmodule

// File: tb/tb_pit_ctrl.sv
// tb_pit_ctrl: directed scenarios followed by a randomized run, every output compared
// each cycle against a behavioural model of the sequencer's rules.
module tb_pit_ctrl;

    localparam int unsigned CS = 16;
    localparam int unsigned PB = 15;
    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_RUN  = 2;
    localparam int P_STOP = 3;

    logic          bus_clk;
    logic          async_rst_b;
    logic          sync_reset;
    logic          cfg_en;
    logic          cfg_one_shot;
    logic          cfg_irq_en;
    logic [3:0]    cfg_pre_sel;
    logic [CS-1:0] cfg_mod;
    logic          cfg_mod_wr;
    logic          irq_clr;
    logic          pit_i;
    logic          counter_sync;
    logic          prescale_out;
    logic          pit_flg_clr;
    logic [CS-1:0] mod_value;
    logic          busy_o;
    logic          done_o;
    logic          irq_o;

    int checks = 0;
    int errors = 0;

    // behavioural model
    int            m_phase;
    int unsigned   m_run_cyc;
    int unsigned   m_sel;
    logic [CS-1:0] m_shadow;
    logic [CS-1:0] m_mod;
    bit            m_pending;
    bit            m_irq;
    bit            m_flg;

    // counter model used to produce pit_i in directed tests
    bit            use_cnt;
    int unsigned   cnt;

    pit_ctrl #(.COUNT_SIZE(CS), .PRE_BITS(PB)) dut (
        .bus_clk      (bus_clk),
        .async_rst_b  (async_rst_b),
        .sync_reset   (sync_reset),
        .cfg_en       (cfg_en),
        .cfg_one_shot (cfg_one_shot),
        .cfg_irq_en   (cfg_irq_en),
        .cfg_pre_sel  (cfg_pre_sel),
        .cfg_mod      (cfg_mod),
        .cfg_mod_wr   (cfg_mod_wr),
        .irq_clr      (irq_clr),
        .pit_i        (pit_i),
        .counter_sync (counter_sync),
        .prescale_out (prescale_out),
        .pit_flg_clr  (pit_flg_clr),
        .mod_value    (mod_value),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .irq_o        (irq_o)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_pre();
        int unsigned period = 32'd1 << m_sel;
        return (m_phase == P_RUN) && ((m_run_cyc % period) == period - 1);
    endfunction

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_run_cyc = 0;
        m_sel     = 0;
        m_shadow  = '0;
        m_mod     = '0;
        m_pending = 0;
        m_irq     = 0;
        m_flg     = 0;
        cnt       = 0;
    endtask

    // advance the model by one clock using the inputs currently applied
    task automatic model_edge();
        bit pit_run;
        if (sync_reset) begin
            m_phase   = P_IDLE;
            m_run_cyc = 0;
            m_irq     = 0;
            m_flg     = 0;
        end else begin
            pit_run = (m_phase == P_RUN) && pit_i;
            if (cfg_mod_wr && pit_run) begin
                m_mod     = cfg_mod;
                m_shadow  = cfg_mod;
                m_pending = 0;
            end else begin
                if (m_pending && (m_phase == P_ARM || pit_run)) begin
                    m_mod     = m_shadow;
                    m_pending = 0;
                end
                if (cfg_mod_wr) begin
                    m_shadow  = cfg_mod;
                    m_pending = 1;
                end
            end
            if (pit_run && cfg_irq_en) m_irq = 1;
            else if (irq_clr)          m_irq = 0;
            m_flg = irq_clr;
            case (m_phase)
                P_IDLE: if (cfg_en) m_phase = P_ARM;
                P_ARM: begin
                    m_phase   = P_RUN;
                    m_run_cyc = 0;
                    m_sel     = (32'(cfg_pre_sel) > PB) ? PB : 32'(cfg_pre_sel);
                end
                P_RUN: begin
                    if (!cfg_en)                      m_phase = P_IDLE;
                    else if (pit_i && cfg_one_shot)   m_phase = P_STOP;
                    else                              m_run_cyc++;
                end
                default: if (!cfg_en) m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic check_all();
        chk("counter_sync", 32'(counter_sync), 32'(m_phase == P_RUN));
        chk("prescale_out", 32'(prescale_out), 32'(exp_pre()));
        chk("pit_flg_clr",  32'(pit_flg_clr),  32'(m_flg));
        chk("mod_value",    32'(mod_value),    32'(m_mod));
        chk("busy_o",       32'(busy_o),       32'(m_phase == P_ARM || m_phase == P_RUN));
        chk("done_o",       32'(done_o),       32'(m_phase == P_STOP));
        chk("irq_o",        32'(irq_o),        32'(m_irq));
    endtask

    task automatic step();
        model_edge();
        @(posedge bus_clk);
        #1;
        check_all();
        if (use_cnt) begin
            pit_i = 1'b0;
            if (m_phase != P_RUN) begin
                cnt = 0;
            end else if (exp_pre()) begin
                cnt++;
                if (cnt >= 32'(m_mod)) begin
                    pit_i = 1'b1;
                    cnt   = 0;
                end
            end
        end
    endtask

    initial begin
        int  n;
        bit  pit_prev;

        async_rst_b  = 1'b0;
        sync_reset   = 1'b0;
        cfg_en       = 1'b0;
        cfg_one_shot = 1'b0;
        cfg_irq_en   = 1'b0;
        cfg_pre_sel  = 4'd0;
        cfg_mod      = '0;
        cfg_mod_wr   = 1'b0;
        irq_clr      = 1'b0;
        pit_i        = 1'b0;
        use_cnt      = 0;
        model_reset();
        @(posedge bus_clk);
        @(posedge bus_clk);
        #1;
        check_all();
        async_rst_b = 1'b1;

        // T1 periodic: mod=4, sel=2
        cfg_mod    = 16'd4;
        cfg_mod_wr = 1'b1;
        step();
        cfg_mod_wr  = 1'b0;
        cfg_pre_sel = 4'd2;
        cfg_irq_en  = 1'b1;
        cfg_en      = 1'b1;
        use_cnt     = 1;
        cnt         = 0;
        step();
        step();
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (prescale_out) n++;
            step();
        end
        chk("t1_prescale_count", 32'(n), 32'd16);
        chk("t1_irq_set", 32'(irq_o), 32'd1);
        use_cnt = 0;
        pit_i   = 1'b0;
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        chk("t1_irq_cleared", 32'(irq_o), 32'd0);
        chk("t1_flg_pulse", 32'(pit_flg_clr), 32'd1);

        // T2 one-shot: mod=3, sel=0
        cfg_en = 1'b0;
        step();
        cfg_mod      = 16'd3;
        cfg_mod_wr   = 1'b1;
        step();
        cfg_mod_wr   = 1'b0;
        cfg_pre_sel  = 4'd0;
        cfg_one_shot = 1'b1;
        cfg_en       = 1'b1;
        use_cnt      = 1;
        cnt          = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done_o) break;
        end
        chk("t2_done", 32'(done_o), 32'd1);
        chk("t2_counter_off", 32'(counter_sync), 32'd0);
        step();
        chk("t2_done_sticky", 32'(done_o), 32'd1);
        cfg_en = 1'b0;
        step();
        chk("t2_done_clr", 32'(done_o), 32'd0);

        // T3 mid-run modulus write: 10 running, write 5
        cfg_one_shot = 1'b0;
        cfg_mod      = 16'd10;
        cfg_mod_wr   = 1'b1;
        step();
        cfg_mod_wr = 1'b0;
        cfg_en     = 1'b1;
        cnt        = 0;
        for (int i = 0; i < 6; i++) step();
        cfg_mod    = 16'd5;
        cfg_mod_wr = 1'b1;
        step();
        cfg_mod_wr = 1'b0;
        chk("t3_mod_held", 32'(mod_value), 32'd10);
        pit_prev = 0;
        for (int i = 0; i < 40; i++) begin
            pit_prev = pit_i;
            if (pit_i) chk("t3_mod_at_pit", 32'(mod_value), 32'd10);
            step();
            if (mod_value == 16'd5) break;
        end
        chk("t3_pit_prev", 32'(pit_prev), 32'd1);
        chk("t3_mod_new", 32'(mod_value), 32'd5);

        // T4 simultaneous write/clear with rollover
        for (int i = 0; i < 40 && !pit_i; i++) step();
        chk("t4_pit_ready", 32'(pit_i), 32'd1);
        chk("t4_irq_before", 32'(irq_o), 32'd1);
        cfg_mod    = 16'd7;
        cfg_mod_wr = 1'b1;
        irq_clr    = 1'b1;
        step();
        cfg_mod_wr = 1'b0;
        irq_clr    = 1'b0;
        chk("t4_mod_direct", 32'(mod_value), 32'd7);
        chk("t4_irq_set_wins", 32'(irq_o), 32'd1);
        chk("t4_flg_pulse", 32'(pit_flg_clr), 32'd1);
        for (int i = 0; i < 20; i++) step();

        // T5 abort, soft reset, hard reset
        use_cnt = 0;
        pit_i   = 1'b0;
        cfg_en  = 1'b0;
        step();
        chk("t5_abort_cs", 32'(counter_sync), 32'd0);
        chk("t5_abort_busy", 32'(busy_o), 32'd0);
        cfg_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("t5_running", 32'(counter_sync), 32'd1);
        sync_reset = 1'b1;
        step();
        sync_reset = 1'b0;
        chk("t5_sr_cs", 32'(counter_sync), 32'd0);
        chk("t5_sr_irq", 32'(irq_o), 32'd0);
        chk("t5_sr_mod_kept", 32'(mod_value), 32'd7);
        for (int i = 0; i < 4; i++) step();
        #2;
        async_rst_b = 1'b0;
        #1;
        chk("t5_ar_cs", 32'(counter_sync), 32'd0);
        chk("t5_ar_busy", 32'(busy_o), 32'd0);
        chk("t5_ar_irq", 32'(irq_o), 32'd0);
        chk("t5_ar_mod", 32'(mod_value), 32'd0);
        model_reset();
        @(posedge bus_clk);
        #1;
        check_all();
        async_rst_b = 1'b1;

        // randomized run
        for (int i = 0; i < 1500; i++) begin
            cfg_en      = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 19) == 0) cfg_one_shot = ~cfg_one_shot;
            cfg_irq_en  = ($urandom_range(0, 3) != 0);
            cfg_pre_sel = 4'($urandom_range(0, 3));
            cfg_mod     = 16'($urandom);
            cfg_mod_wr  = ($urandom_range(0, 9) == 0);
            irq_clr     = ($urandom_range(0, 9) == 0);
            pit_i       = ($urandom_range(0, 6) == 0);
            sync_reset  = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
